// File: rtl/sgdmac_desc_fetch.sv
// -----------------------------------------------------------------------------
// sgdmac_desc_fetch
// Scatter-gather descriptor fetcher. Starting from a pointer supplied by the
// config block, it walks a linked list of 16-byte descriptors over an AXI read
// port (one 4-beat INCR burst per descriptor). It hands each non-empty
// descriptor to the data-mover engine and reports done once the whole list has
// been executed.
//
// Descriptor layout (32-bit words):
//   w0 = src, w1 = dst, w2[LEN_W-1:0] = len, w3 = {next[31:4], 3'b0, last}
//
// Optional feature macro: SGDMAC_RRESP_CHECK_EN
//   defined     : a non-OKAY rresp on any beat sets the sticky err_o, drains
//                 the burst, discards that descriptor and ends the list.
//   not defined : rresp_i is ignored and err_o is tied low.
// -----------------------------------------------------------------------------
module sgdmac_desc_fetch #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int LEN_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      start_pointer_i,
    input  logic             start_i,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      araddr_o,
    output logic [3:0]       arlen_o,
    output logic [2:0]       arsize_o,
    output logic [1:0]       arburst_o,
    output logic             arvalid_o,
    input  logic             arready_i,
    input  logic [31:0]      rdata_i,
    input  logic [1:0]       rresp_i,
    input  logic             rlast_i,
    input  logic             rvalid_i,
    output logic             rready_o,
    output logic [31:0]      desc_src_o,
    output logic [31:0]      desc_dst_o,
    output logic [LEN_W-1:0] desc_len_o,
    output logic             desc_valid_o,
    input  logic             desc_ready_i,
    input  logic             desc_done_i
);

    localparam logic [2:0] MAX_OS = 3'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_PUSH  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [1:0]       beat_q, beat_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [27:0]      next_q, next_d;
    logic             last_q, last_d;
    logic [2:0]       os_q, os_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rerr_q, rerr_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             dvalid_q, dvalid_d;

    logic             ar_hs_s;
    logic             r_hs_s;
    logic             d_hs_s;
    logic             done_ev_s;
    logic             beat_err_s;
    logic             advance_s;
    logic             unused_s;

    // Handshake qualifiers; a completion pulse with nothing outstanding is dropped.
    assign ar_hs_s   = arvalid_q & arready_i;
    assign r_hs_s    = rready_q & rvalid_i;
    assign d_hs_s    = dvalid_q & desc_ready_i;
    assign done_ev_s = desc_done_i & (os_q != 3'd0);

`ifdef SGDMAC_RRESP_CHECK_EN
    assign beat_err_s = r_hs_s & (rresp_i != 2'b00);
`else
    assign beat_err_s = 1'b0;
`endif

    // rlast_i is not used: the internal beat counter decides the burst end.
    assign unused_s = ^{rlast_i, rresp_i, start_pointer_i[3:0]};

    assign arlen_o      = 4'd3;
    assign arsize_o     = 3'd2;
    assign arburst_o    = 2'b01;
    assign araddr_o     = ptr_q;
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign desc_valid_o = dvalid_q;
    assign desc_src_o   = src_q;
    assign desc_dst_o   = dst_q;
    assign desc_len_o   = len_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

    // Next-state logic: list walk FSM, outstanding counter and registered outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        next_d    = next_q;
        last_d    = last_q;
        err_d     = err_q;
        rerr_d    = rerr_q;
        advance_s = 1'b0;

        // Outstanding count: push and completion in the same cycle cancel out.
        case ({d_hs_s, done_ev_s})
            2'b10:   os_d = os_q + 3'd1;
            2'b01:   os_d = os_q - 3'd1;
            default: os_d = os_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RADDR;
                    ptr_d   = {start_pointer_i[31:4], 4'h0};
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RADDR: begin
                if (ar_hs_s) begin
                    state_d = S_RDATA;
                    beat_d  = 2'd0;
                    rerr_d  = 1'b0;
                end else begin
                    state_d = S_RADDR;
                end
            end
            S_RDATA: begin
                if (r_hs_s) begin
                    case (beat_q)
                        2'd0:    src_d = rdata_i;
                        2'd1:    dst_d = rdata_i;
                        2'd2:    len_d = rdata_i[LEN_W-1:0];
                        2'd3: begin
                            next_d = rdata_i[31:4];
                            last_d = rdata_i[0];
                        end
                        default: src_d = src_q;
                    endcase
                    if (beat_err_s) begin
                        rerr_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        rerr_d = rerr_q;
                    end
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        // A faulted descriptor is dropped and the walk ends.
                        if (rerr_q | beat_err_s) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_PUSH;
                        end
                    end else begin
                        state_d = S_RDATA;
                    end
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_PUSH: begin
                // Zero-length descriptors are skipped as if already accepted.
                if (len_q == {LEN_W{1'b0}}) begin
                    advance_s = 1'b1;
                end else if (d_hs_s) begin
                    advance_s = 1'b1;
                end else begin
                    advance_s = 1'b0;
                end
                if (advance_s) begin
                    if (last_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RADDR;
                        ptr_d   = {next_q, 4'h0};
                    end
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_DRAIN: begin
                if (os_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the next state so they are valid the cycle the state is.
        arvalid_d = (state_d == S_RADDR);
        rready_d  = (state_d == S_RDATA);
        done_d    = (state_d == S_IDLE);
        dvalid_d  = (state_d == S_PUSH) && (len_d != {LEN_W{1'b0}}) && (os_d < MAX_OS);
    end

    // State and output registers with asynchronous reset to the idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 32'd0;
            beat_q    <= 2'd0;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            len_q     <= {LEN_W{1'b0}};
            next_q    <= 28'd0;
            last_q    <= 1'b0;
            os_q      <= 3'd0;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            rerr_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            dvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            beat_q    <= beat_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            next_q    <= next_d;
            last_q    <= last_d;
            os_q      <= os_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rerr_q    <= rerr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            dvalid_q  <= dvalid_d;
        end
    end

endmodule
